// File: rtl/flag_event_logger.sv
// Flag change event logger: timestamps edges on a flag vector and queues
// {timestamp, flags, change_mask} entries in a show-ahead FIFO with overflow tracking.
module flag_event_logger #(
  parameter int unsigned FLAG_W = 6,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FLAG_W-1:0]          flags_in,
  input  logic                       en,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [TS_W+2*FLAG_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = TS_W + 2 * FLAG_W;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [FLAG_W-1:0] prev_q;
  logic              primed_q;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic [FLAG_W-1:0] change;
  logic [EW-1:0]     entry;
  logic              event_hit, full, pop, wr, drop;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    change     = flags_in ^ prev_q;
    entry      = {ts_q, flags_in, change};
    event_hit  = primed_q && en && (|change);
    full       = (count_q == CW'(DEPTH));
    pop        = rd_en && (count_q != '0);
    // A pop at the same edge frees a slot, so a full FIFO still accepts the event.
    wr         = event_hit && (!full || pop);
    drop       = event_hit && full && !pop;
    wptr_d     = wr  ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q;
    if (wr && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr) begin
      count_d = count_q - CW'(1);
    end
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= flags_in;
      primed_q   <= 1'b1;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr_q] <= entry;
    end
  end

  always_comb begin
    rd_valid   = (count_q != '0);
    rd_data    = mem_q[rptr_q];
    fifo_count = count_q;
    overflow   = overflow_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule

// File: doc/flag_event_logger.md
FLAG_EVENT_LOGGER -- requirements
Module: flag_event_logger

Interface
REQ-001 SHALL have parameter FLAG_W, default 6, number of monitored flag bits.
REQ-002 SHALL have parameter TS_W, default 16, timestamp counter width.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2 and at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flags_in  input  FLAG_W  monitored flags, synchronous to clk.
REQ-007 SHALL have port en  input  1  event capture enable.
REQ-008 SHALL have port rd_en  input  1  consumer pop request.
REQ-009 SHALL have port clr_ovf  input  1  clear overflow and drop count.
REQ-010 SHALL have port rd_valid  output  1  FIFO non-empty; rd_data valid.
REQ-011 SHALL have port rd_data  output  TS_W+2*FLAG_W  head entry {timestamp, flags, change_mask}, timestamp in MSBs.
REQ-012 SHALL have port fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky: at least one event dropped.
REQ-014 SHALL have port drop_cnt  output  8  dropped-event count, saturating.

Function
REQ-015 SHALL run free timestamp ts_cnt, +1 every clk edge, wrapping 2^TS_W-1 -> 0, independent of en.
REQ-016 SHALL register prev_flags <= flags_in every edge, regardless of en.
REQ-017 SHALL hold primed bit, 0 after reset, set on first edge after reset; no event is generated on the edge where primed is 0.
REQ-018 SHALL raise an event at an edge when primed=1, en=1, and change = flags_in XOR prev_flags is non-zero.
REQ-019 SHALL form the entry as {ts_cnt value before the edge, flags_in, change}.
REQ-020 SHALL write the entry at the event edge when not full or when a pop occurs at the same edge; rd_valid high after that edge (1-cycle latency).
REQ-021 SHALL implement a show-ahead FIFO: rd_data = oldest entry whenever rd_valid=1; rd_data don't-care when empty.
REQ-022 SHALL pop at an edge when rd_en=1 and rd_valid=1; rd_en while empty is ignored, no state change.
REQ-023 SHALL, when empty with simultaneous event and rd_en, write the entry and not pop; no bypass.
REQ-024 SHALL, when full with simultaneous event and pop, do both; fifo_count stays DEPTH; no drop.
REQ-025 SHALL, when full with event and no pop, discard the entry, set overflow, and increment drop_cnt, saturating at 255.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; fifo_count ranges 0..DEPTH.
REQ-027 SHALL, on clr_ovf=1, clear overflow and drop_cnt; a drop at the same edge leaves overflow=1, drop_cnt=1.
REQ-028 SHALL ignore flag changes while en=0; no deferred event when en returns to 1, because prev_flags kept tracking.

Reset
REQ-029 SHALL, on rst_n low, immediately clear ts_cnt, prev_flags, primed, pointers, fifo_count, overflow, and drop_cnt; rd_valid=0.
REQ-030 SHALL resume operation on the first rising edge after rst_n deasserts; reset mid-operation discards all FIFO contents.

Verification
REQ-031 SHALL pass: reset with flags_in=6'h3F, en=1, held static -> no entry; rd_valid stays 0.
REQ-032 SHALL pass: flags_in 6'h00 -> 6'h05 at the edge where ts_cnt=10 -> one entry {16'd10, 6'h05, 6'h05}; rd_valid=1 one edge later.
REQ-033 SHALL pass: 10 consecutive single-bit changes, no rd_en -> fifo_count=8, overflow=1, drop_cnt=2; pops return the first 8 entries in order.
REQ-034 SHALL pass: full FIFO, event plus rd_en at the same edge -> fifo_count stays 8, drop_cnt unchanged, newest entry at tail.
REQ-035 SHALL pass: en=0 while flags toggle 6'h00 -> 6'h01 -> 6'h00, then en=1 with flags static -> no entries.
REQ-036 SHALL pass: rst_n pulsed low asynchronously between edges with 3 entries -> fifo_count=0, rd_valid=0, ts_cnt=0 immediately.
